// File: rtl/ram_fill_writer.sv
// Write-side burst sequencer for the 64x8 dual-clock RAM: turns a valid/ready byte stream
// into RAM writes at wrapping addresses. Optional running checksum: RAM_FILL_WRITER_CHECKSUM_EN.
module ram_fill_writer #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  write_clock,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] start_addr,
    input  logic [ADDR_WIDTH:0]   length,
    input  logic                  abort,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] data,
    output logic [ADDR_WIDTH-1:0] write_addr,
    output logic                  we,
    output logic                  busy,
    output logic                  done,
`ifdef RAM_FILL_WRITER_CHECKSUM_EN
    output logic [DATA_WIDTH-1:0] checksum,
`endif
    output logic [ADDR_WIDTH:0]   count
);

    localparam logic [ADDR_WIDTH:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0] ONE   = {{ADDR_WIDTH{1'b0}}, 1'b1};

    typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] ptr;
    logic [ADDR_WIDTH:0]   remaining;
    logic [ADDR_WIDTH:0]   len_eff;
    logic                  accept;

    always_comb begin
        in_ready = (state == WRITE) && !abort;
        accept   = in_valid && in_ready;
        len_eff  = (length > DEPTH) ? DEPTH : length;
    end

    always_ff @(posedge write_clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            ptr        <= '0;
            remaining  <= '0;
            data       <= '0;
            write_addr <= '0;
            we         <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            count      <= '0;
`ifdef RAM_FILL_WRITER_CHECKSUM_EN
            checksum   <= '0;
`endif
        end else begin
            we   <= 1'b0;
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        count <= '0;
`ifdef RAM_FILL_WRITER_CHECKSUM_EN
                        checksum <= '0;
`endif
                        if (length != '0) begin
                            ptr       <= start_addr;
                            remaining <= len_eff;
                            busy      <= 1'b1;
                            state     <= WRITE;
                        end else begin
                            // Zero-length burst completes immediately without leaving IDLE
                            done <= 1'b1;
                        end
                    end
                end
                WRITE: begin
                    if (abort) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (accept) begin
                        we         <= 1'b1;
                        data       <= in_data;
                        write_addr <= ptr;
                        ptr        <= ptr + 1'b1;
                        remaining  <= remaining - 1'b1;
                        count      <= count + 1'b1;
`ifdef RAM_FILL_WRITER_CHECKSUM_EN
                        checksum   <= checksum + in_data;
`endif
                        // done lines up with the final write, both visible in the DONE cycle
                        if (remaining == ONE) begin
                            done  <= 1'b1;
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/ram_fill_writer.md
Name: ram_fill_writer

Overview:
- Write-side sequencer in the write-clock domain of the 64x8 dual-clock RAM.
- Accepts a valid/ready byte stream and a burst descriptor (start address, length).
- Drives the RAM write port (data, write_addr, we): one write per accepted byte, addresses incrementing with wrap-around.
- Signals completion so the read side can be told when a buffer region is filled.

Parameters:
DATA_WIDTH, 8, width of stream bytes and RAM data
ADDR_WIDTH, 6, RAM address width (depth = 2**ADDR_WIDTH = 64)

Ports:
write_clock  in  1  sole clock, rising edge
reset_n  in  1  asynchronous active-low reset
start  in  1  begin burst; sampled only in IDLE
start_addr  in  ADDR_WIDTH  first RAM address of burst
length  in  ADDR_WIDTH+1  bytes in burst, 0..64; values >64 clamped to 64
abort  in  1  terminate burst; sampled only in WRITE
in_data  in  DATA_WIDTH  stream byte
in_valid  in  1  in_data valid
in_ready  out  1  writer accepts byte this cycle
data  out  DATA_WIDTH  RAM write data
write_addr  out  ADDR_WIDTH  RAM write address
we  out  1  RAM write enable
busy  out  1  high in WRITE and DONE
done  out  1  one-cycle completion pulse
count  out  ADDR_WIDTH+1  bytes written in current/last burst

Behaviour:
- Reset (reset_n low, asynchronous):
  - State IDLE; internal pointer and remaining count cleared.
  - data, write_addr, we, busy, done, count all 0.
- States: IDLE, WRITE, DONE.
- IDLE:
  - in_ready = 0, we = 0.
  - start=1 with length!=0: latch ptr=start_addr, remaining=min(length,64), clear count; go to WRITE.
  - start=1 with length==0: done=1 next cycle, count=0, remain in IDLE, no write.
- WRITE:
  - in_ready = 1 while abort=0; in_ready is combinational from state and abort.
  - Accept = in_valid & in_ready at a rising edge.
  - On accept, registered outputs in the next cycle: we=1, data=in_data, write_addr=ptr.
  - Also on accept: ptr <= ptr+1 mod 64 (63 wraps to 0), remaining decrements, count increments.
  - No accept: we=0; data and write_addr hold their previous values.
  - Accept of the last byte (remaining==1): go to DONE; in_ready is low from the next cycle.
  - abort=1: in_ready=0, so no accept; go to IDLE next cycle with no done pulse; count keeps the bytes already written.
- DONE (one cycle):
  - we=1 for the final byte and done=1 in the same cycle.
  - busy=1; then IDLE.
- Latency: byte accepted at edge N appears on the RAM write port in the cycle following edge N (1 cycle).
- Bursts of 64 starting at any address write every location exactly once.
- start is ignored while busy.
- start in the cycle immediately after DONE is honoured (back-to-back bursts, one idle cycle between).
- Reset mid-burst: immediate return to reset values; a pending write is dropped.

Optional Feature:
- Macro RAM_FILL_WRITER_CHECKSUM_EN.
- Defined:
  - Adds output checksum [DATA_WIDTH-1:0], the mod-256 sum of all bytes accepted in the current burst.
  - Cleared on reset and on burst start.
  - Final value valid in the DONE cycle and held until the next start.
  - Aborted bursts hold their partial sum.
- Undefined: no checksum port or logic; all other behaviour identical.

Test Plan:
- Reset: reset_n low mid-WRITE -> we, done, busy, count, data, write_addr all 0 immediately; in_ready=0.
- Basic: start_addr=5, length=3, in_valid held high with bytes 0xA1,0xA2,0xA3 -> we high 3 consecutive cycles at addr 5,6,7 with data A1,A2,A3; done pulses with the addr-7 write; count=3.
- Wrap plus backpressure: start_addr=62, length=4, in_valid toggling 1,0,1,1,0,1 -> writes at 62,63,0,1 only in cycles after accepted bytes; we low after idle beats; done once.
- Abort: length=10, abort asserted after 4 accepts -> 4 writes, no done, busy drops next cycle, count=4, next start accepted.
- Edge lengths: length=0 -> done pulse, no we, count=0. length=100 -> clamps to 64, exactly 64 writes covering every address once.
- Checksum (macro defined): bytes 0xFF,0x02,0x10 -> checksum=0x11 in the DONE cycle.
